// File: rtl/fp_soc_pio_pulse_if.sv
// Avalon-MM slave bus bundle for fp_soc_pio_pulse: word address, chipselect,
// active-low write strobe, 32-bit write data and zero-wait-state read data.
interface fp_soc_pio_pulse_if;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address,
        output chipselect,
        output write_n,
        output writedata,
        input  readdata
    );

    modport slave (
        input  address,
        input  chipselect,
        input  write_n,
        input  writedata,
        output readdata
    );
endinterface

// File: rtl/fp_soc_pio_pulse.sv
// Avalon-MM PIO: data_out with atomic set/clear, self-timed pulse register,
// synchronised input port. Edge capture / IRQ only when FP_PIO_EDGE_IRQ_EN is defined.
module fp_soc_pio_pulse #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE  = '0,
    parameter int               PULSE_CYCLES = 16,
    parameter int               EDGE_TYPE    = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    fp_soc_pio_pulse_if.slave bus,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] out_port,
    output logic             irq
);

    localparam int            CW       = $clog2(PULSE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(PULSE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic             w_wr;
    logic [WIDTH-1:0] w_wd;
    logic             w_unused_bits;

    logic [WIDTH-1:0] r_data_out;
    logic [WIDTH-1:0] r_sync1;
    logic [WIDTH-1:0] r_sync2;
    logic [WIDTH-1:0] r_pulse_bits;
    logic [CW-1:0]    r_pulse_cnt;
    logic [WIDTH-1:0] w_irqmask_rd;
    logic [WIDTH-1:0] w_edgecap_rd;

    assign w_wr          = bus.chipselect & ~bus.write_n;
    assign w_wd          = bus.writedata[WIDTH-1:0];
    // Upper writedata bits are ignored when WIDTH < 32.
    assign w_unused_bits = ^bus.writedata;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= RESET_VALUE;
        end else if (w_wr) begin
            case (bus.address)
                3'd0:    r_data_out <= w_wd;
                3'd4:    r_data_out <= r_data_out | w_wd;
                3'd5:    r_data_out <= r_data_out & ~w_wd;
                default: r_data_out <= r_data_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_port;
            r_sync2 <= r_sync1;
        end
    end

    // A new non-zero trigger takes priority over expiry, so retriggering on
    // the last cycle keeps the pulse alive and extends every active bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pulse_bits <= '0;
            r_pulse_cnt  <= '0;
        end else if (w_wr && (bus.address == 3'd6) && (w_wd != '0)) begin
            r_pulse_bits <= r_pulse_bits | w_wd;
            r_pulse_cnt  <= CNT_LOAD;
        end else if (r_pulse_cnt != '0) begin
            r_pulse_cnt <= r_pulse_cnt - CNT_ONE;
            if (r_pulse_cnt == CNT_ONE) begin
                r_pulse_bits <= '0;
            end
        end
    end

    assign out_port = r_data_out | r_pulse_bits;

`ifdef FP_PIO_EDGE_IRQ_EN
    logic [WIDTH-1:0] r_prev;
    logic [WIDTH-1:0] r_edgecap;
    logic [WIDTH-1:0] r_irqmask;
    logic [WIDTH-1:0] w_edge;
    logic [WIDTH-1:0] w_clr;

    generate
        if (EDGE_TYPE == 0) begin : g_rise
            assign w_edge = r_sync2 & ~r_prev;
        end else if (EDGE_TYPE == 1) begin : g_fall
            assign w_edge = ~r_sync2 & r_prev;
        end else begin : g_any
            assign w_edge = r_sync2 ^ r_prev;
        end
    endgenerate

    assign w_clr = (w_wr && (bus.address == 3'd3)) ? w_wd : '0;

    // A detected edge beats a simultaneous write-1-to-clear on the same bit.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_prev    <= '0;
            r_edgecap <= '0;
            r_irqmask <= '0;
        end else begin
            r_prev    <= r_sync2;
            r_edgecap <= (r_edgecap & ~w_clr) | w_edge;
            if (w_wr && (bus.address == 3'd2)) begin
                r_irqmask <= w_wd;
            end
        end
    end

    assign irq          = |(r_edgecap & r_irqmask);
    assign w_irqmask_rd = r_irqmask;
    assign w_edgecap_rd = r_edgecap;
`else
    localparam int unused_edge_type = EDGE_TYPE;

    assign irq          = 1'b0;
    assign w_irqmask_rd = '0;
    assign w_edgecap_rd = '0;
`endif

    always_comb begin
        bus.readdata = '0;
        case (bus.address)
            3'd0:    bus.readdata[WIDTH-1:0] = r_data_out;
            3'd1:    bus.readdata[WIDTH-1:0] = r_sync2;
            3'd2:    bus.readdata[WIDTH-1:0] = w_irqmask_rd;
            3'd3:    bus.readdata[WIDTH-1:0] = w_edgecap_rd;
            3'd6:    bus.readdata[WIDTH-1:0] = r_pulse_bits;
            default: bus.readdata = '0;
        endcase
    end

endmodule
